sd_cache_lock_arbiter: RTL
==========================

SD_CACHE_LOCK_ARBITER -- requirements
Module: sd_cache_lock_arbiter

Interface
REQ-001 SHALL provide parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL provide parameter: TMO_W, 16, width of hold-timeout counter.
REQ-003 SHALL provide port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL provide port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port: acq_req  in  NUM_REQ  per-requester lock acquire request (level).
REQ-006 SHALL provide port: rel_req  in  NUM_REQ  per-requester lock release request (level).
REQ-007 SHALL provide port: tmo_cycles  in  TMO_W  max hold cycles; 0 disables timeout.
REQ-008 SHALL provide port: grant  out  NUM_REQ  one-hot current owner; all-zero when unlocked.
REQ-009 SHALL provide port: owner_id  out  clog2(NUM_REQ)  index of current or last owner.
REQ-010 SHALL provide port: lock_status  out  1  1 = cache locked.
REQ-011 SHALL provide port: lock  out  1  one-cycle pulse to cache manager on acquisition.
REQ-012 SHALL provide port: unlock  out  1  one-cycle pulse to cache manager on release.
REQ-013 SHALL provide port: tmo_err  out  1  one-cycle pulse when owner forcibly released by timeout.
REQ-014 SHALL provide port: bad_rel  out  1  one-cycle pulse when a non-owner asserts rel_req while LOCKED.

Function
REQ-015 SHALL implement FSM states IDLE, LOCKED, UNLOCK; all outputs registered.
REQ-016 IDLE: if any acq_req bit set at edge t, SHALL enter LOCKED at t+1 with grant one-hot, lock=1 for that cycle, lock_status=1, hold counter=0.
REQ-017 Winner SHALL be selected round-robin: first set acq_req bit searching from (owner_id+1) mod NUM_REQ upward with wrap.
REQ-018 LOCKED: grant, owner_id, lock_status SHALL stay constant; acq_req from any requester, including owner, SHALL be ignored.
REQ-019 LOCKED: hold counter SHALL increment once per cycle, saturating at all-ones.
REQ-020 LOCKED: rel_req[owner] SHALL move FSM to UNLOCK next cycle.
REQ-021 LOCKED: tmo_cycles!=0 and counter==tmo_cycles-1 SHALL move FSM to UNLOCK next cycle with tmo_err=1 in that UNLOCK cycle.
REQ-022 Owner release and timeout in same cycle SHALL be treated as release; tmo_err stays 0.
REQ-023 rel_req from non-owner in LOCKED SHALL pulse bad_rel next cycle with no state change; multiple such bits give a single pulse.
REQ-024 UNLOCK: grant=0, lock_status=0, unlock=1 for exactly one cycle; owner_id retained; FSM SHALL return to IDLE unconditionally.
REQ-025 Requests present in UNLOCK SHALL NOT be granted until the IDLE cycle; minimum release-to-regrant gap is 2 cycles.
REQ-026 rel_req in IDLE or UNLOCK SHALL be ignored; no bad_rel.
REQ-027 lock and unlock SHALL never be 1 in the same cycle; grant SHALL never have more than one bit set.
REQ-028 tmo_cycles SHALL be sampled every LOCKED cycle; changing it mid-hold takes effect immediately.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, grant=0, lock_status=0 (unlocked), lock=0, unlock=0, tmo_err=0, bad_rel=0, counter=0, owner_id=NUM_REQ-1 (so requester 0 wins first).
REQ-030 Reset asserted in LOCKED SHALL drop the lock without an unlock pulse; after deassertion no state SHALL persist and lock_status SHALL be 0 until a new acquisition.

Verification
REQ-031 Reset then acq_req=4'b0110 -> grant=4'b0010 one cycle later, lock pulse, lock_status=1, owner_id=1.
REQ-032 Owner 1 rel_req, then acq_req=4'b1111 held -> UNLOCK cycle (unlock=1), IDLE, then grant=4'b0100; subsequent rotation 3,0,1.
REQ-033 tmo_cycles=5, owner never releases -> UNLOCK exactly 5 cycles after the lock cycle, tmo_err=1 with unlock=1.
REQ-034 Owner 2 locked, rel_req=4'b1001 -> bad_rel pulse, grant stays 4'b0100; tmo_cycles=0 -> no timeout after 70000 cycles.
REQ-035 rst_n low mid-LOCKED -> grant=0, lock_status=0 immediately (asynchronous), no unlock pulse; after release, acq_req=4'b1000 -> grant=4'b1000.
REQ-036 Release and timeout coincident -> unlock=1, tmo_err=0.

Source files
------------

// File: rtl/sd_cache_lock_arbiter.sv
// Cache lock arbiter: one requester owns the cache lock at a time.
// Round-robin grant, owner or timeout release, and one-cycle lock/unlock/error pulses.
module sd_cache_lock_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int TMO_W   = 16,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] acq_req,
  input  logic [NUM_REQ-1:0] rel_req,
  input  logic [TMO_W-1:0]   tmo_cycles,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    owner_id,
  output logic               lock_status,
  output logic               lock,
  output logic               unlock,
  output logic               tmo_err,
  output logic               bad_rel
);

  typedef enum logic [1:0] {IDLE, LOCKED, UNLOCK} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic               lock_status_q, lock_status_d;
  logic               lock_q, lock_d, unlock_q, unlock_d;
  logic               tmo_err_q, tmo_err_d, bad_rel_q, bad_rel_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    win, idx;
  logic               found;

  // Round-robin search starting just after the last owner.
  always_comb begin
    win   = owner_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(owner_q) + i) % NUM_REQ);
      if (!found && acq_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    lock_status_d = lock_status_q;
    cnt_d         = cnt_q;
    lock_d        = 1'b0;
    unlock_d      = 1'b0;
    tmo_err_d     = 1'b0;
    bad_rel_d     = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d       = '0;
        lock_status_d = 1'b0;
        if (|acq_req) begin
          state_d       = LOCKED;
          grant_d       = '0;
          grant_d[win]  = 1'b1;
          owner_d       = win;
          lock_status_d = 1'b1;
          lock_d        = 1'b1;
          cnt_d         = '0;
        end
      end
      LOCKED: begin
        if (cnt_q != {TMO_W{1'b1}}) cnt_d = cnt_q + TMO_W'(1);
        bad_rel_d = |(rel_req & ~grant_q);
        // Owner release wins over a coincident timeout.
        if (|(rel_req & grant_q)) begin
          state_d       = UNLOCK;
          grant_d       = '0;
          lock_status_d = 1'b0;
          unlock_d      = 1'b1;
        end else if (tmo_cycles != '0 && cnt_q == tmo_cycles - TMO_W'(1)) begin
          state_d       = UNLOCK;
          grant_d       = '0;
          lock_status_d = 1'b0;
          unlock_d      = 1'b1;
          tmo_err_d     = 1'b1;
        end
      end
      UNLOCK: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        lock_status_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= ID_W'(NUM_REQ - 1);
      lock_status_q <= 1'b0;
      lock_q        <= 1'b0;
      unlock_q      <= 1'b0;
      tmo_err_q     <= 1'b0;
      bad_rel_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      lock_status_q <= lock_status_d;
      lock_q        <= lock_d;
      unlock_q      <= unlock_d;
      tmo_err_q     <= tmo_err_d;
      bad_rel_q     <= bad_rel_d;
      cnt_q         <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign owner_id    = owner_q;
  assign lock_status = lock_status_q;
  assign lock        = lock_q;
  assign unlock      = unlock_q;
  assign tmo_err     = tmo_err_q;
  assign bad_rel     = bad_rel_q;

endmodule
